// File: rtl/bram_seq_pkg.sv
// Shared types and constants for the BRAM playback sequencer.
package bram_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } seq_state_t;

   localparam int PASS_W = 16;

   function automatic logic [PASS_W-1:0] sat_inc(input logic [PASS_W-1:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/seq_rate_tick.sv
// Read-rate down-counter: ticks at zero, reloads the decimation value on
// each tick, and sits at zero (ticking) whenever it is not enabled.
module seq_rate_tick #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic [W-1:0] reload_i,
   output logic         tick_o
);

   localparam logic [W-1:0] ONE = 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i)       cnt_d = '0;
      else if (tick_o) cnt_d = reload_i;
      else             cnt_d = cnt_q - ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/bram_playback_sequencer.sv
// Plays a window of BRAM samples to the DAC path at a programmable rate,
// optionally looping, with a two-stage read/output pipeline.
module bram_playback_sequencer
   import bram_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 10,
   parameter int DECIM_WIDTH = 16
) (
   input  logic                  fpga_clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [ADDR_WIDTH-1:0] cfg_base,
   input  logic [ADDR_WIDTH:0]   cfg_len,
   input  logic                  cfg_loop,
   input  logic [DECIM_WIDTH-1:0] cfg_decim,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_we,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic [PASS_W-1:0]     pass_count
);

   localparam logic [ADDR_WIDTH:0]   MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   ONE_L   = 1;
   localparam logic [ADDR_WIDTH-1:0] ONE_A   = 1;

   seq_state_t             state_q;
   logic [ADDR_WIDTH-1:0]  base_q, off_q, addr_q;
   logic [ADDR_WIDTH:0]    len_q;
   logic                   loop_q;
   logic [DECIM_WIDTH-1:0] decim_q;
   logic                   v1_q, last1_q;
   logic [DATA_WIDTH-1:0]  out_data_q;
   logic                   out_valid_q, busy_q, done_q, cfg_err_q;
   logic [PASS_W-1:0]      pass_q;

   logic                   tick, issue, last_rd, len_ok;
   logic [ADDR_WIDTH-1:0]  rd_addr;

   seq_rate_tick #(.W(DECIM_WIDTH)) u_tick (
      .clk      (fpga_clk),
      .rst_n    (rst_n),
      .en_i     (state_q == S_RUN),
      .reload_i (decim_q),
      .tick_o   (tick)
   );

   // The address is presented combinationally in the issue cycle so the
   // BRAM captures it on that edge; otherwise the last read address is held.
   assign issue     = (state_q == S_RUN) && tick && !stop;
   assign rd_addr   = base_q + off_q;
   assign last_rd   = ({1'b0, off_q} == (len_q - ONE_L));
   assign len_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN);
   assign bram_addr = issue ? rd_addr : addr_q;
   assign bram_we   = 1'b0;

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cfg_err    = cfg_err_q;
   assign pass_count = pass_q;

   always_ff @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         loop_q      <= 1'b0;
         decim_q     <= '0;
         off_q       <= '0;
         addr_q      <= '0;
         v1_q        <= 1'b0;
         last1_q     <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         pass_q      <= '0;
      end else begin
         cfg_err_q   <= 1'b0;
         done_q      <= 1'b0;
         // stop kills the read whose data is on bram_dout this cycle
         out_valid_q <= v1_q && !stop;
         if (v1_q && !stop) out_data_q <= bram_dout;
         v1_q    <= issue;
         last1_q <= issue && last_rd;
         if (issue) addr_q <= rd_addr;

         case (state_q)
            S_IDLE: begin
               if (start && !stop) begin
                  if (len_ok) begin
                     base_q  <= cfg_base;
                     len_q   <= cfg_len;
                     loop_q  <= cfg_loop;
                     decim_q <= cfg_decim;
                     off_q   <= '0;
                     pass_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (stop) begin
                  done_q  <= 1'b1;
                  state_q <= S_DRAIN;
               end else if (issue) begin
                  if (last_rd) begin
                     off_q  <= '0;
                     pass_q <= sat_inc(pass_q);
                     if (!loop_q) state_q <= S_DRAIN;
                  end else begin
                     off_q <= off_q + ONE_A;
                  end
               end
            end
            S_DRAIN: begin
               // done_q marks the final busy cycle for both normal and aborted ends
               if (done_q) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (stop || (v1_q && last1_q)) begin
                  done_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/bram_playback_sequencer.md
BRAM_PLAYBACK_SEQUENCER -- requirements
Module: bram_playback_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, sample width; ADDR_WIDTH, default 10, BRAM address width; DECIM_WIDTH, default 16, decimation field width.
REQ-002 The module SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port fpga_clk, input, 1 bit: the single clock, which is the fpga-side BRAM port clock.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start, input, 1 bit: level-sampled request to begin playback.
REQ-006 Port stop, input, 1 bit: level-sampled abort.
REQ-007 Port cfg_base, input, ADDR_WIDTH bits: first sample address.
REQ-008 Port cfg_len, input, ADDR_WIDTH+1 bits: samples per pass; the legal range is 1..2**ADDR_WIDTH.
REQ-009 Port cfg_loop, input, 1 bit: 1 means repeat passes until stop.
REQ-010 Port cfg_decim, input, DECIM_WIDTH bits: one read is issued every cfg_decim+1 cycles.
REQ-011 Port bram_addr, output, ADDR_WIDTH bits: BRAM port A address.
REQ-012 Port bram_we, output, 1 bit: BRAM port A write enable, constant 0.
REQ-013 Port bram_dout, input, DATA_WIDTH bits: BRAM port A read data, 1-cycle read latency.
REQ-014 Port out_data, output, DATA_WIDTH bits: registered sample to the DAC path.
REQ-015 Port out_valid, output, 1 bit: out_data is new in this cycle.
REQ-016 Port busy, output, 1 bit: a playback is active.
REQ-017 Port done, output, 1 bit: one-cycle end-of-playback pulse.
REQ-018 Port cfg_err, output, 1 bit: one-cycle pulse when start is rejected.
REQ-019 Port pass_count, output, 16 bits: completed passes, saturating.

Function
REQ-020 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-021 In IDLE, start=1 with stop=0 and cfg_len in 1..2**ADDR_WIDTH SHALL latch cfg_base, cfg_len, cfg_loop and cfg_decim, clear pass_count and enter RUN.
REQ-022 In IDLE, start=1 with cfg_len=0 or cfg_len>2**ADDR_WIDTH SHALL pulse cfg_err for one cycle and stay in IDLE.
REQ-023 In IDLE, start=1 and stop=1 in the same cycle SHALL be ignored, with no cfg_err pulse.
REQ-024 start SHALL be ignored in RUN and DRAIN; configuration inputs SHALL be ignored outside the start-acceptance cycle.
REQ-025 Reads SHALL be issued on the first RUN cycle and then every cfg_decim+1 cycles; decim=0 gives one read per cycle.
REQ-026 The address of read i SHALL be (cfg_base+i) mod 2**ADDR_WIDTH within a pass; after the last sample the offset SHALL wrap to 0.
REQ-027 Each issued read SHALL produce out_valid=1, with out_data = bram_dout, exactly 2 cycles after its address is driven (1 cycle BRAM latency plus 1 cycle output register).
REQ-028 pass_count SHALL increment when the final read of a pass is issued and SHALL saturate at 16'hFFFF.
REQ-029 With cfg_loop=0, issuing the final read SHALL move the FSM to DRAIN; no further reads SHALL be issued.
REQ-030 With cfg_loop=1, RUN SHALL continue seamlessly into the next pass with no gap in read cadence.
REQ-031 In DRAIN, done SHALL pulse in the same cycle as the last out_valid, and the FSM SHALL enter IDLE on the next edge.
REQ-032 stop=1 in RUN or DRAIN SHALL issue no further reads, suppress out_valid for any in-flight read, pulse done in the next cycle and then return to IDLE.
REQ-033 busy SHALL be 1 from the cycle after start acceptance through the done cycle, inclusive.
REQ-034 bram_addr SHALL hold its last value when no read is issued.

Reset
REQ-035 When rst_n=0, the FSM SHALL enter IDLE and all outputs and latched configuration SHALL be 0 (bram_addr=0, out_data=0, out_valid=0, busy=0, done=0, cfg_err=0, pass_count=0).
REQ-036 Reset asserted mid-playback SHALL abort it with no done pulse; in-flight reads SHALL produce no out_valid after reset release.

Structure
REQ-037 The shared package bram_seq_pkg SHALL hold the FSM state enumeration and the pass_count width constant (16).
REQ-038 The read-rate down-counter SHALL be a sub-module named seq_rate_tick: reload cfg_decim, tick at 0, cleared on leaving RUN.

Verification
REQ-039 Scenario: base=0, len=4, loop=0, decim=0, RAM[i]=i -> out_valid on 4 consecutive cycles with data 0,1,2,3; done coincides with data 3; pass_count=1.
REQ-040 Scenario: base=1022, len=4, ADDR_WIDTH=10 -> addresses 1022,1023,0,1.
REQ-041 Scenario: len=3, decim=2, loop=1, run 3 passes -> one out_valid every 3 cycles, data repeats with period 3, pass_count=3.
REQ-042 Scenario: stop asserted the cycle after a read issue -> that sample is never valid; done pulses next cycle; busy falls after it.
REQ-043 Scenario: cfg_len=0 then cfg_len=1025 -> cfg_err pulse each time, busy stays 0; start and stop together -> no response.
REQ-044 Scenario: rst_n low mid-pass with loop=1 -> all outputs 0 asynchronously; no out_valid or done after release.
